// File: rtl/apb_audio_stream_ctrl.sv
// rtl/apb_audio_stream_ctrl.sv - APB audio frame FIFO with programmable sample tick
//
// Purpose: APB zero-wait slave that assembles interleaved N-channel samples
// into frames, queues them in a frame FIFO and, while playing, presents one
// frame per sample tick on audio_out. Raises a level-crossing refill
// interrupt and keeps sticky underrun/overflow flags.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   PSEL, PENABLE, PWRITE    APB control
//   PADDR, PWDATA            APB byte address / write data
//   PRDATA, PREADY, PSLVERR  APB read data, ready (always 1), error
//   audio_out                current frame, channel 0 in the LSBs
//   tick_out                 one-cycle sample strobe
//   play_out                 play mode active
//   irq_out                  refill interrupt
module apb_audio_stream_ctrl #(
  parameter int          CHANNELS    = 2,
  parameter int          SAMPLE_W    = 24,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h8C00_0000,
  parameter int          DEFAULT_DIV = 1023
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [31:0]                  PADDR,
  input  logic [31:0]                  PWDATA,
  output logic [31:0]                  PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  output logic [CHANNELS*SAMPLE_W-1:0] audio_out,
  output logic                         tick_out,
  output logic                         play_out,
  output logic                         irq_out
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int FRAME_W = CHANNELS * SAMPLE_W;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] IRQ_LEVEL = CNT_W'(FIFO_DEPTH / 2 + 1);

  localparam logic [1:0] REG_CMD    = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_DATA   = 2'd3;

  // address decode
  logic [31:0] offset;
  logic        in_range;
  logic [1:0]  reg_sel;
  logic        wr_access;
  logic        cmd_wr, div_wr, data_wr;
  logic        start_cmd, stop_cmd, clr_cmd, ack_cmd;

  // frame FIFO
  logic [FRAME_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wptr, rptr;
  logic [CNT_W-1:0]    count;
  logic                full, empty;

  // staging of a partially written frame
  logic [SAMPLE_W-1:0] stage [CHANNELS];
  logic [IDX_W-1:0]    idx;
  logic [FRAME_W-1:0]  push_frame;

  // tick generator
  logic [15:0] div_reg, div_act, tick_cnt;
  logic [15:0] tick_cnt_n, div_act_n;
  logic        wrap, tick_n;

  logic        underrun, overflow;
  logic        pop, push_req, push_ok, drop, irq_set;
  logic [31:0] status_word;
  logic        unused_bits;

  assign offset    = PADDR - BASE_ADDR;
  assign in_range  = (offset[31:4] == 28'd0);
  assign reg_sel   = offset[3:2];
  assign wr_access = PSEL && PENABLE && PWRITE && in_range;
  assign cmd_wr    = wr_access && (reg_sel == REG_CMD);
  assign div_wr    = wr_access && (reg_sel == REG_DIV);
  assign data_wr   = wr_access && (reg_sel == REG_DATA);

  assign stop_cmd  = cmd_wr && PWDATA[1];
  assign start_cmd = cmd_wr && PWDATA[0] && !PWDATA[1];
  assign clr_cmd   = cmd_wr && PWDATA[2];
  assign ack_cmd   = cmd_wr && PWDATA[3];

  assign full   = (count == DEPTH_CNT);
  assign empty  = (count == '0);
  assign PREADY = 1'b1;

  assign unused_bits = ^{PWDATA, offset[1:0]};

  // The active divider is latched at START and at every wrap so a DIV write
  // during play only shapes the following period. tick_out is registered and
  // high exactly while the counter sits at the active divider value.
  always_comb begin
    wrap       = play_out && (tick_cnt == div_act);
    tick_cnt_n = wrap ? 16'd0 : tick_cnt + 16'd1;
    div_act_n  = wrap ? div_reg : div_act;
    tick_n     = play_out && !start_cmd && !stop_cmd && (tick_cnt_n == div_act_n);
  end

  // A pop frees a slot in the same edge, so a push to a full FIFO that
  // coincides with a pop is accepted.
  assign pop      = tick_n && !empty;
  assign push_req = data_wr && (idx == LAST_IDX);
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && !push_ok;
  assign PSLVERR  = drop;
  assign irq_set  = play_out && pop && !push_ok && (count == IRQ_LEVEL);

  // The last sample of a frame goes straight into the pushed word.
  always_comb begin
    push_frame = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      push_frame[c*SAMPLE_W +: SAMPLE_W] =
        (IDX_W'(c) == idx) ? PWDATA[SAMPLE_W-1:0] : stage[c];
    end
  end

  always_comb begin
    status_word        = '0;
    status_word[0]     = play_out;
    status_word[1]     = irq_out;
    status_word[2]     = underrun;
    status_word[3]     = overflow;
    status_word[4]     = full;
    status_word[5]     = empty;
    status_word[15:8]  = 8'(count);
    status_word[18:16] = 3'(idx);
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL && in_range) begin
      case (reg_sel)
        REG_STATUS: PRDATA = status_word;
        REG_DIV:    PRDATA = {16'h0000, div_reg};
        default:    PRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= push_frame;
    end
    if (data_wr) begin
      stage[idx] <= PWDATA[SAMPLE_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      play_out  <= 1'b0;
      tick_out  <= 1'b0;
      irq_out   <= 1'b0;
      audio_out <= '0;
      tick_cnt  <= '0;
      div_act   <= 16'(DEFAULT_DIV);
      div_reg   <= 16'(DEFAULT_DIV);
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      idx       <= '0;
      underrun  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (stop_cmd) begin
        play_out <= 1'b0;
        tick_cnt <= '0;
        tick_out <= 1'b0;
      end else if (start_cmd) begin
        play_out <= 1'b1;
        tick_cnt <= '0;
        div_act  <= div_reg;
        tick_out <= 1'b0;
      end else if (play_out) begin
        tick_cnt <= tick_cnt_n;
        div_act  <= div_act_n;
        tick_out <= tick_n;
      end

      if (div_wr) begin
        div_reg <= PWDATA[15:0];
      end

      if (data_wr) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end

      if (push_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        audio_out <= mem[rptr];
        rptr      <= rptr + 1'b1;
      end
      if (push_ok && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push_ok) begin
        count <= count - 1'b1;
      end

      if (tick_n && empty) begin
        underrun <= 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end

      // a new crossing outranks an acknowledge in the same cycle
      if (stop_cmd || clr_cmd) begin
        irq_out <= 1'b0;
      end else if (irq_set) begin
        irq_out <= 1'b1;
      end else if (ack_cmd) begin
        irq_out <= 1'b0;
      end

      if (clr_cmd) begin
        wptr      <= '0;
        rptr      <= '0;
        count     <= '0;
        idx       <= '0;
        audio_out <= '0;
        underrun  <= 1'b0;
        overflow  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apb_audio_stream_ctrl.sv
// tb/tb_apb_audio_stream_ctrl.sv - self-checking bench for apb_audio_stream_ctrl
module tb_apb_audio_stream_ctrl;

  localparam int          CH      = 2;
  localparam int          SW      = 24;
  localparam int          DEPTH   = 16;
  localparam logic [31:0] BASE    = 32'h8C00_0000;
  localparam int          DEF_DIV = 1023;
  localparam logic [31:0] A_CMD    = BASE;
  localparam logic [31:0] A_STATUS = BASE + 32'h4;
  localparam logic [31:0] A_DIV    = BASE + 32'h8;
  localparam logic [31:0] A_DATA   = BASE + 32'hC;

  typedef logic [CH*SW-1:0] frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  frame_t      audio_out;
  logic        tick_out, play_out, irq_out;

  apb_audio_stream_ctrl #(
    .CHANNELS(CH), .SAMPLE_W(SW), .FIFO_DEPTH(DEPTH),
    .BASE_ADDR(BASE), .DEFAULT_DIV(DEF_DIV)
  ) dut (
    .clk(clk), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .audio_out(audio_out), .tick_out(tick_out),
    .play_out(play_out), .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: frames in a queue, tick times from the number of
  // edges elapsed since START and the divider then in force.
  frame_t      mq[$];
  logic [SW-1:0] mstage [CH];
  int          m_idx;
  bit          m_play, m_irq, m_under, m_over, m_tick;
  int          m_div, m_div_run;
  longint      cyc, m_start;
  frame_t      m_audio;
  logic [31:0] m_exp_rdata;
  bit          m_exp_err;

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = m_play;
    s[1]     = m_irq;
    s[2]     = m_under;
    s[3]     = m_over;
    s[4]     = (mq.size() == DEPTH);
    s[5]     = (mq.size() == 0);
    s[15:8]  = 8'(mq.size());
    s[18:16] = 3'(m_idx);
    return s;
  endfunction

  logic [31:0] mo_off;
  bit          mo_acc, mo_inr, mo_cmd, mo_start, mo_stop, mo_clr, mo_ack, mo_data;
  bit          mo_pop, mo_push, mo_last, mo_isset;
  int          mo_pre;
  longint      mo_k;
  frame_t      mo_f;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      mq.delete();
      m_idx = 0; m_play = 0; m_irq = 0; m_under = 0; m_over = 0; m_tick = 0;
      m_div = DEF_DIV; m_div_run = DEF_DIV; m_audio = '0; m_start = cyc;
    end else begin
      mo_acc   = PSEL && PENABLE;
      mo_off   = PADDR - BASE;
      mo_inr   = (mo_off < 32'd16);
      mo_cmd   = mo_acc && mo_inr && PWRITE && (mo_off[3:2] == 2'd0);
      mo_data  = mo_acc && mo_inr && PWRITE && (mo_off[3:2] == 2'd3);
      mo_stop  = mo_cmd && PWDATA[1];
      mo_start = mo_cmd && PWDATA[0] && !PWDATA[1];
      mo_clr   = mo_cmd && PWDATA[2];
      mo_ack   = mo_cmd && PWDATA[3];

      m_exp_rdata = '0;
      if (PSEL && mo_inr && mo_off[3:2] == 2'd1) m_exp_rdata = model_status();
      if (PSEL && mo_inr && mo_off[3:2] == 2'd2) m_exp_rdata = 32'(m_div);

      mo_k   = cyc - m_start;
      m_tick = m_play && !mo_start && !mo_stop && (mo_k > 0) &&
               ((mo_k % (m_div_run + 1)) == m_div_run);
      mo_pre = mq.size();
      mo_pop = m_tick && (mo_pre > 0);
      if (m_tick && mo_pre == 0) m_under = 1;

      mo_push = 0; m_exp_err = 0;
      if (mo_data) begin
        mstage[m_idx] = PWDATA[SW-1:0];
        mo_last = (m_idx == CH - 1);
        m_idx   = mo_last ? 0 : m_idx + 1;
        if (mo_last) begin
          if (mo_pre < DEPTH || mo_pop) mo_push = 1;
          else begin m_exp_err = 1; m_over = 1; end
        end
      end

      if (mo_pop) m_audio = mq.pop_front();
      if (mo_push) begin
        for (int c = 0; c < CH; c++) mo_f[c*SW +: SW] = mstage[c];
        mq.push_back(mo_f);
      end

      mo_isset = m_play && mo_pop && !mo_push && (mo_pre == DEPTH / 2 + 1);
      if (mo_stop || mo_clr) m_irq = 0;
      else if (mo_isset) m_irq = 1;
      else if (mo_ack) m_irq = 0;

      if (mo_acc && mo_inr && PWRITE && mo_off[3:2] == 2'd2) m_div = int'(PWDATA[15:0]);

      if (mo_stop) m_play = 0;
      else if (mo_start) begin m_play = 1; m_start = cyc; m_div_run = m_div; end

      if (mo_clr) begin
        mq.delete(); m_idx = 0; m_audio = '0; m_under = 0; m_over = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check_eq("tick_out", tick_out, m_tick);
      check_eq("play_out", play_out, m_play);
      check_eq("irq_out", irq_out, m_irq);
      check_eq("audio_out", audio_out, m_audio);
      check_eq("pready", PREADY, 1'b1);
    end
  end

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic err);
    @(negedge clk);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = addr; PWDATA = data;
    @(negedge clk);
    PENABLE = 1;
    #1 err = PSLVERR;
    @(posedge clk);
    #1 check_eq("pslverr_model", err, m_exp_err);
    PSEL = 0; PENABLE = 0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
    @(negedge clk);
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = addr;
    @(negedge clk);
    PENABLE = 1;
    #1 begin data = PRDATA; err = PSLVERR; end
    @(posedge clk);
    #1 check_eq("prdata_model", data, m_exp_rdata);
    check_eq("rd_pslverr", err, 1'b0);
    PSEL = 0; PENABLE = 0;
  endtask

  initial begin
    logic        err, anyerr;
    logic [31:0] rd;
    int          n, r;
    logic [31:0] addr;

    repeat (3) @(negedge clk);
    rst = 0;
    chk_en = 1;
    check_eq("rst_audio", audio_out, '0);
    check_eq("rst_play", play_out, 1'b0);
    apb_read(A_STATUS, rd, err); check_eq("rst_status", rd, 32'h20);
    apb_read(A_DIV, rd, err);    check_eq("rst_div", rd, 32'd1023);
    apb_read(A_CMD, rd, err);    check_eq("cmd_reads0", rd, 32'h0);

    // first frame, then tick cadence with DIV=3
    apb_write(A_DATA, 32'h0011_1111, err);
    apb_write(A_DATA, 32'h0022_2222, err);
    apb_read(A_STATUS, rd, err); check_eq("one_frame_status", rd, 32'h100);
    apb_write(A_DIV, 32'd3, err);
    apb_write(A_CMD, 32'h1, err);
    n = 0; do begin @(negedge clk); n++; end while (!tick_out && n < 64);
    check_eq("first_tick_latency", n, 4);
    check_eq("first_tick_audio", audio_out, 48'h222222_111111);
    n = 0; do begin @(negedge clk); n++; end while (!tick_out && n < 64);
    check_eq("tick_period", n, 4);
    check_eq("underrun_audio_held", audio_out, 48'h222222_111111);
    apb_read(A_STATUS, rd, err); check_eq("underrun_flag", rd[2], 1'b1);

    // fill to full, then overflow
    apb_write(A_CMD, 32'h2, err);
    apb_write(A_CMD, 32'h4, err);
    anyerr = 0;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      apb_write(A_DATA, $urandom, err);
      anyerr |= err;
    end
    check_eq("fill_no_err", anyerr, 1'b0);
    apb_write(A_DATA, 32'h0000_0ABC, err); check_eq("ovf_first_half", err, 1'b0);
    apb_write(A_DATA, 32'h0000_0DEF, err); check_eq("ovf_pslverr", err, 1'b1);
    apb_read(A_STATUS, rd, err); check_eq("full_status", rd, 32'h1018);

    // drain at DIV=0, refill interrupt at 9 -> 8
    apb_write(A_DIV, 32'd0, err);
    apb_write(A_CMD, 32'h1, err);
    n = 0; do begin @(negedge clk); n++; end while (!irq_out && n < 40);
    check_eq("irq_cycle", n, 9);
    apb_write(A_CMD, 32'h8, err);
    check_eq("irq_ack", irq_out, 1'b0);
    repeat (12) @(negedge clk);
    check_eq("irq_no_refire", irq_out, 1'b0);
    apb_write(A_CMD, 32'h2, err);

    // partial frame discarded by CLR, START|STOP keeps play off
    apb_write(A_CMD, 32'h4, err);
    apb_write(A_DATA, 32'h00AB_CDEF, err);
    apb_read(A_STATUS, rd, err); check_eq("partial_status", rd, 32'h0001_0020);
    apb_write(A_CMD, 32'h4, err);
    apb_read(A_STATUS, rd, err); check_eq("clr_status", rd, 32'h20);
    check_eq("clr_audio", audio_out, '0);
    apb_write(A_CMD, 32'h3, err);
    check_eq("start_stop_play", play_out, 1'b0);

    // reset in the middle of play
    for (int i = 0; i < 2 * 5; i++) apb_write(A_DATA, $urandom, err);
    apb_write(A_DIV, 32'd100, err);
    apb_write(A_CMD, 32'h1, err);
    repeat (20) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check_eq("midrst_play", play_out, 1'b0);
    check_eq("midrst_tick", tick_out, 1'b0);
    check_eq("midrst_audio", audio_out, '0);
    rst = 0;
    apb_read(A_STATUS, rd, err); check_eq("midrst_status", rd, 32'h20);
    apb_read(A_DIV, rd, err);    check_eq("midrst_div", rd, 32'd1023);

    // outside the window
    apb_write(BASE + 32'h10, 32'h1, err); check_eq("oor_wr_err", err, 1'b0);
    apb_read(BASE + 32'h10, rd, err);     check_eq("oor_rd", rd, 32'h0);
    check_eq("oor_play", play_out, 1'b0);
    apb_read(A_STATUS, rd, err); check_eq("oor_status", rd, 32'h20);

    // randomized traffic against the model
    for (int it = 0; it < 600; it++) begin
      r = $urandom_range(0, 99);
      if (r < 45) apb_write(A_DATA, $urandom, err);
      else if (r < 55) apb_read(A_STATUS, rd, err);
      else if (r < 59) apb_read(A_DIV, rd, err);
      else if (r < 67) repeat ($urandom_range(1, 6)) @(negedge clk);
      else if (r < 75) begin
        if (!m_play) apb_write(A_DIV, $urandom_range(0, 4), err);
        apb_write(A_CMD, 32'h1, err);
      end
      else if (r < 80) apb_write(A_CMD, 32'h2, err);
      else if (r < 86) apb_write(A_CMD, 32'h8, err);
      else if (r < 89) apb_write(A_CMD, 32'h4, err);
      else if (r < 91) apb_write(A_CMD, 32'h3, err);
      else if (r < 96) begin
        addr = (r[0]) ? BASE + 32'h10 + ($urandom_range(0, 15) << 2) : BASE - 32'h4;
        if (r[1]) apb_write(addr, $urandom, err);
        else apb_read(addr, rd, err);
      end
      else if (!m_play) apb_write(A_DIV, $urandom_range(0, 6), err);
    end

    @(negedge clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
